i2s_master_tx: RTL

I2S_MASTER_TX -- requirements
Module: i2s_master_tx

---
 rtl/i2s_master_tx.sv | 76 +++++++
 1 files changed

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter; 16-bit stereo pairs sent in 64-bit frames.
// BCLK is CLOCK_50 / (2*BCLK_DIV); one frame spans 128*BCLK_DIV cycles.
module i2s_master_tx #(
   parameter int BCLK_DIV = 8
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   output logic        BCLK,
   output logic        LRCLK,
   output logic        DACDAT,
   output logic        frame_start,
   output logic        underflow
);
   logic [7:0]  div;
   logic [5:0]  bit_cnt, bit_nxt;
   logic [4:0]  pos, idx;
   logic        full, tick, fall, load, accept, bit_val;
   logic [15:0] hold_l, hold_r, frame_l, frame_r, word;

   assign tick         = div == 8'(BCLK_DIV - 1);
   assign fall         = tick && BCLK;
   assign load         = fall && bit_cnt == 6'd63;
   assign accept       = sample_valid && !full;
   assign sample_ready = !full;
   assign bit_nxt      = bit_cnt + 6'd1;
   assign pos          = bit_nxt[4:0];
   assign idx          = 5'd16 - pos;
   assign word         = bit_nxt[5] ? frame_r : frame_l;
   // Slot position 0 is the idle bit after each LRCLK edge, so the MSB lands one BCLK later.
   assign bit_val      = (pos != 5'd0 && pos <= 5'd16) ? word[idx[3:0]] : 1'b0;

   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         div         <= '0;
         BCLK        <= 1'b0;
         bit_cnt     <= '1;
         LRCLK       <= 1'b0;
         DACDAT      <= 1'b0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         div         <= tick ? '0 : div + 8'd1;
         BCLK        <= tick ? !BCLK : BCLK;
         frame_start <= load;
         underflow   <= load && !full;
         if (fall) begin
            bit_cnt <= bit_nxt;
            LRCLK   <= bit_nxt[5];
            DACDAT  <= bit_val;
         end
      end

   // Load reads the pre-edge full flag; a coincident accept lands in holding for the next frame.
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         full    <= 1'b0;
         hold_l  <= '0;
         hold_r  <= '0;
         frame_l <= '0;
         frame_r <= '0;
      end else begin
         full <= accept || (full && !load);
         if (accept) begin
            hold_l <= left_in;
            hold_r <= right_in;
         end
         if (load) begin
            frame_l <= full ? hold_l : 16'h0;
            frame_r <= full ? hold_r : 16'h0;
         end
      end
endmodule
